uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port uart_rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-007 SHALL have port uart_rx_en  input  1  receive enable.
REQ-008 SHALL have port uart_rx_data  output  PAYLOAD_BITS  last received payload.
REQ-009 SHALL have port uart_rx_valid  output  1  one-cycle pulse when uart_rx_data is updated.
REQ-010 SHALL have port uart_rx_break  output  1  one-cycle pulse on a break frame.
REQ-011 SHALL have port uartbusy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012 SHALL pass uart_rxd through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-013 SHALL use CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer) and a bit-timer counter of width clog2(CYCLES_PER_BIT)+1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-027).
REQ-015 IDLE->START on a synchronized high-to-low transition while uart_rx_en=1; the bit timer is cleared.
REQ-016 START SHALL re-sample the line at CYCLES_PER_BIT/2; low -> DATA with the timer cleared; high -> IDLE as a glitch, with no output pulse.
REQ-017 DATA SHALL sample once per CYCLES_PER_BIT, at the bit midpoint, shifting LSB first; after PAYLOAD_BITS samples -> STOP (or PARITY).
REQ-018 STOP SHALL sample at the midpoint; high -> load uart_rx_data and pulse uart_rx_valid for exactly 1 cycle; then -> IDLE immediately (no wait for the bit end).
REQ-019 STOP sampled low with all payload bits 0 SHALL pulse uart_rx_break for 1 cycle, leave uart_rx_data unchanged, suppress valid, and -> IDLE.
REQ-020 STOP sampled low with non-zero payload (framing error) SHALL suppress valid and break and -> IDLE.
REQ-021 uart_rx_valid SHALL rise 1 cycle after the stop-bit midpoint sample; uart_rx_data SHALL hold its value until the next valid frame.
REQ-022 Deasserting uart_rx_en in any non-IDLE state SHALL abort to IDLE on the next edge with no pulses.
REQ-023 While the line is held low after a break or framing error, IDLE SHALL NOT start a new frame until a high-to-low edge is seen.
REQ-024 uart_rx_valid and uart_rx_break SHALL never be high in the same cycle.

Reset
REQ-025 On reset: state=IDLE, synchronizer=1, timer=0, shift register=0, uart_rx_data=0, uart_rx_valid=0, uart_rx_break=0, uartbusy=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only on a fresh start edge.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, an even-parity bit SHALL follow the payload (state PARITY, midpoint-sampled); on mismatch, valid SHALL be suppressed and output uart_rx_parity_err (1 bit, reset 0) SHALL pulse for 1 cycle at the stop sample. Without the macro, there is no PARITY state and no uart_rx_parity_err port, and frames are start+payload+stop.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state enum, the CYCLES_PER_BIT computation function, and the default BIT_RATE/PAYLOAD_BITS constants, shared with uart_tx.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff; the remaining logic stays in uart_rx.

Verification (CLK_HZ=50000000, BIT_RATE=9600, CYCLES_PER_BIT=5208)
REQ-030 Frame 0xA5 with stop=1 and en=1 -> uart_rx_data=0xA5 with a 1-cycle valid pulse; uartbusy is low afterwards.
REQ-031 Low glitch of 1000 cycles on an idle line -> no valid, no break; uartbusy returns to 0 by the START midpoint.
REQ-032 Line held low for 12 bit times -> a single break pulse, valid=0, uart_rx_data unchanged; a following 0x3C frame is received correctly.
REQ-033 Back-to-back frames 0x01 then 0xFE, with no idle gap beyond the stop bit -> two valid pulses carrying 0x01 and 0xFE.
REQ-034 Reset pulsed during data bit 3 of 0x55, then a 0x0F frame -> no output for 0x55; 0x0F is received.
REQ-035 UART_RX_PARITY_EN build: 0x07 sent with parity=0 -> parity_err pulse, no valid; sent with parity=1 -> valid with 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-timing helper and default
// line settings used by both uart_rx and uart_tx.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

    localparam int DEFAULT_BIT_RATE     = 9600;
    localparam int DEFAULT_PAYLOAD_BITS = 8;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;
`endif

    // Whole clock cycles per serial bit (truncating division).
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
// Both stages reset to 1 so a reset never looks like a start edge.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, midpoint sampling, LSB-first payload,
// break and framing-error detection. Frames: start + payload + stop.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the
// payload and the uart_rx_parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_break,
`ifdef UART_RX_PARITY_EN
    output logic                    uart_rx_parity_err,
`endif
    output logic                    uartbusy
);

    localparam int CPB     = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int TIMER_W = $clog2(CPB) + 1;
    localparam int CNT_W   = $clog2(PAYLOAD_BITS) + 1;

    localparam logic [TIMER_W-1:0] HALF_END_C = TIMER_W'(CPB / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_END_C  = TIMER_W'(CPB - 1);
    localparam logic [CNT_W-1:0]   LAST_BIT_C = CNT_W'(PAYLOAD_BITS - 1);

    uart_state_t             state_r;
    uart_state_t             state_nxt_s;
    logic                    rxd_s;
    logic                    rxd_prev_r;
    logic [TIMER_W-1:0]      timer_r;
    logic [PAYLOAD_BITS-1:0] shift_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic                    fall_s;
    logic                    half_tick_s;
    logic                    bit_tick_s;
    logic                    last_bit_s;
    logic                    sample_s;
    logic                    stop_sample_s;
    logic                    valid_nxt_s;
    logic                    break_nxt_s;
`ifdef UART_RX_PARITY_EN
    logic                    parity_bit_r;
    logic                    parity_ok_s;
    logic                    perr_nxt_s;

    // Even parity: payload XOR parity bit must be zero.
    function automatic logic even_parity(input logic [PAYLOAD_BITS-1:0] v);
        return ^v;
    endfunction
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rxd),
        .q     (rxd_s)
    );

    assign fall_s      = rxd_prev_r & ~rxd_s;
    assign half_tick_s = (timer_r == HALF_END_C);
    assign bit_tick_s  = (timer_r == BIT_END_C);
    assign last_bit_s  = (bit_cnt_r == LAST_BIT_C);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; dropping the enable aborts any frame in progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (uart_rx_en && fall_s) state_nxt_s = ST_START;
                else                      state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (!uart_rx_en)      state_nxt_s = ST_IDLE;
                else if (half_tick_s) state_nxt_s = rxd_s ? ST_IDLE : ST_DATA;
                else                  state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (!uart_rx_en)                   state_nxt_s = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                else if (bit_tick_s && last_bit_s) state_nxt_s = ST_PARITY;
`else
                else if (bit_tick_s && last_bit_s) state_nxt_s = ST_STOP;
`endif
                else                               state_nxt_s = ST_DATA;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (!uart_rx_en)     state_nxt_s = ST_IDLE;
                else if (bit_tick_s) state_nxt_s = ST_STOP;
                else                 state_nxt_s = ST_PARITY;
            end
`endif
            ST_STOP: begin
                if (!uart_rx_en)     state_nxt_s = ST_IDLE;
                else if (bit_tick_s) state_nxt_s = ST_IDLE;
                else                 state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode: sample strobes and next values of the output pulses.
    always_comb begin
        case (state_r)
            ST_START: sample_s = half_tick_s;
            ST_DATA:  sample_s = bit_tick_s;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: sample_s = bit_tick_s;
`endif
            ST_STOP:  sample_s = bit_tick_s;
            default:  sample_s = 1'b0;
        endcase
        stop_sample_s = (state_r == ST_STOP) && uart_rx_en && bit_tick_s;
`ifdef UART_RX_PARITY_EN
        parity_ok_s = (even_parity(shift_r) == parity_bit_r);
        valid_nxt_s = stop_sample_s && rxd_s && parity_ok_s;
        perr_nxt_s  = stop_sample_s && rxd_s && !parity_ok_s;
`else
        valid_nxt_s = stop_sample_s && rxd_s;
`endif
        break_nxt_s = stop_sample_s && !rxd_s && (shift_r == '0);
    end

    // Bit timer, edge-detect history, payload shifter and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_prev_r <= 1'b1;
            timer_r    <= '0;
            shift_r    <= '0;
            bit_cnt_r  <= '0;
`ifdef UART_RX_PARITY_EN
            parity_bit_r <= 1'b0;
`endif
        end else begin
            rxd_prev_r <= rxd_s;
            if ((state_r == ST_IDLE) || sample_s) timer_r <= '0;
            else                                  timer_r <= timer_r + TIMER_W'(1);
            if ((state_r == ST_DATA) && sample_s) begin
                shift_r   <= {rxd_s, shift_r[PAYLOAD_BITS-1:1]};
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end else if (state_r != ST_DATA) begin
                bit_cnt_r <= '0;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
`ifdef UART_RX_PARITY_EN
            if ((state_r == ST_PARITY) && sample_s) parity_bit_r <= rxd_s;
            else                                    parity_bit_r <= parity_bit_r;
`endif
        end
    end

    // Registered outputs: data holds between valid frames, pulses last one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uartbusy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            uart_rx_parity_err <= 1'b0;
`endif
        end else begin
            if (valid_nxt_s) uart_rx_data <= shift_r;
            else             uart_rx_data <= uart_rx_data;
            uart_rx_valid <= valid_nxt_s;
            uart_rx_break <= break_nxt_s;
            uartbusy      <= (state_nxt_s != ST_IDLE);
`ifdef UART_RX_PARITY_EN
            uart_rx_parity_err <= perr_nxt_s;
`endif
        end
    end

endmodule
